// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the writeback path.
// Contents:
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : geometry of the register file
//   REG_ZERO                           : address of the hard-wired zero register
//   wb_req_t                           : one writeback source's request bundle
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker.
// Ports:
//   req     in  N      request vector
//   ptr     in  PTR_W  index with highest priority this cycle
//   gnt     out N      one-hot grant, all-zero when no request
//   gnt_idx out PTR_W  index of the granted request (0 when none)
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    // Walk the requesters starting at ptr and wrapping modulo N; the first
    // active one wins. found stops later candidates from overriding it.
    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among NREQ writeback sources.
// Round-robin grant with valid/ready handshake; the accepted write appears on
// the registered outputs one cycle later. Writes to x0 are accepted but never
// strobed.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   req_valid   per-requester write pending
//   req_addr    packed destinations, requester i at [i*ADDR_W +: ADDR_W]
//   req_data    packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot-or-zero grant
//   writeS      registered write strobe
//   address3    registered write address
//   writeData   registered write data
//   wr_pending  copy of writeS for hazard logic
//   commit_cnt  saturating count of strobed writes
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   writeS,
    output logic [ADDR_W-1:0]      address3,
    output logic [DATA_W-1:0]      writeData,
    output logic                   wr_pending,
    output logic [CNT_W-1:0]       commit_cnt
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              write_s_q, write_s_d;
    logic [ADDR_W-1:0] address3_q, address3_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;

    logic [NREQ-1:0]   gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              xfer;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    rr_arbiter #(.N(NREQ), .PTR_W(PTR_W)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are suppressed during reset so no requester believes its write
    // was taken while the output stage is being cleared.
    assign req_ready = rst ? '0 : gnt;
    assign xfer      = (|gnt) && !rst;

    // Only the granted slice is ever selected, and it is only consumed when
    // xfer is set, so idle requesters' addr/data cannot leak to the outputs.
    assign gnt_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign gnt_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    // Next-state for output stage, pointer and counter. The counter advances
    // together with the strobe it counts, so commit_cnt already includes the
    // write currently on the port.
    always_comb begin
        write_s_d    = 1'b0;
        address3_d   = address3_q;
        write_data_d = write_data_q;
        rr_ptr_d     = rr_ptr_q;
        commit_cnt_d = commit_cnt_q;
        if (xfer) begin
            write_s_d    = (gnt_addr != ADDR_W'(REG_ZERO));
            address3_d   = gnt_addr;
            write_data_d = gnt_data;
            rr_ptr_d     = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if (write_s_d && (commit_cnt_q != {CNT_W{1'b1}})) begin
            commit_cnt_d = commit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            write_s_q    <= 1'b0;
            address3_q   <= '0;
            write_data_q <= '0;
            commit_cnt_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            write_s_q    <= write_s_d;
            address3_q   <= address3_d;
            write_data_q <= write_data_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign writeS     = write_s_q;
    assign wr_pending = write_s_q;
    assign address3   = address3_q;
    assign writeData  = write_data_q;
    assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a behavioural reference model.
module tb_regfile_write_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   writeS;
    logic [ADDR_W-1:0]      address3;
    logic [DATA_W-1:0]      writeData;
    logic                   wr_pending;
    logic [CNT_W-1:0]       commit_cnt;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .writeS     (writeS),
        .address3   (address3),
        .writeData  (writeData),
        .wr_pending (wr_pending),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain integers describing what the port must show.
    int               m_ptr;
    bit               m_ws;
    int               m_addr;
    longint           m_data;
    int               m_cnt;
    logic [NREQ-1:0]  m_last_gnt;
    logic [DATA_W-1:0] regs [32];

    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_ws = 0; m_addr = 0; m_data = 0; m_cnt = 0;
            m_last_gnt = '0;
        end else begin
            int g;
            g = model_grant();
            m_last_gnt = '0;
            if (g >= 0) begin
                m_last_gnt[g] = 1'b1;
                m_addr = int'(req_addr[g*ADDR_W +: ADDR_W]);
                m_data = longint'(req_data[g*DATA_W +: DATA_W]);
                m_ws   = (m_addr != 0);
                m_ptr  = (g + 1) % NREQ;
                if (m_ws && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end else begin
                m_ws = 0;
            end
        end
    end

    // Register file sink: commits on the negedge after the strobe.
    always @(negedge clk) begin
        if (writeS) regs[address3] = writeData;
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checkOutput("req_ready", longint'(req_ready), longint'(exp_rdy));
        checkOutput("writeS", longint'(writeS), longint'(m_ws));
        checkOutput("wr_pending", longint'(wr_pending), longint'(m_ws));
        checkOutput("address3", longint'(address3), longint'(m_addr));
        checkOutput("writeData", longint'(writeData), m_data);
        checkOutput("commit_cnt", longint'(commit_cnt), longint'(m_cnt));
    end

    task automatic applyStimulus(input logic [NREQ-1:0] v,
                                 input int a0, input int a1, input int a2,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2);
        req_valid = v;
        req_addr  = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
        req_data  = {d2, d1, d0};
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] cur_v;
        int              cur_a [NREQ];
        logic [31:0]     cur_d [NREQ];

        rst = 1'b1;
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;

        // Single request from requester 0.
        step();
        applyStimulus(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0);
        #1 checkOutput("single_ready", longint'(req_ready), 64'h1);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("single_writeS", longint'(writeS), 64'h1);
        checkOutput("single_addr", longint'(address3), 64'd5);
        checkOutput("single_data", longint'(writeData), 64'hDEADBEEF);
        checkOutput("single_cnt", longint'(commit_cnt), 64'd1);

        // All three valid for six cycles from a fresh pointer.
        step();
        pulseReset();
        step();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(3'b111, 1, 2, 3, 32'h100 + c, 32'h200 + c, 32'h300 + c);
            #1 checkOutput("rr_grant", longint'(req_ready), longint'(1 << (c % 3)));
            if (c > 0) checkOutput("rr_strobe", longint'(writeS), 64'h1);
            step();
        end
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("rr_last_strobe", longint'(writeS), 64'h1);
        checkOutput("rr_cnt", longint'(commit_cnt), 64'd6);

        // Write to x0 from requester 1.
        step();
        applyStimulus(3'b010, 0, 0, 0, 0, 32'h1234, 0);
        #1 checkOutput("x0_ready", longint'(req_ready), 64'h2);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("x0_writeS", longint'(writeS), 64'h0);
        checkOutput("x0_cnt", longint'(commit_cnt), 64'd6);

        // Collision on register 7 with the pointer now at 2.
        step();
        applyStimulus(3'b101, 7, 0, 7, 32'hA, 0, 32'hB);
        #1 checkOutput("coll_first", longint'(req_ready), 64'h4);
        step();
        applyStimulus(3'b001, 7, 0, 0, 32'hA, 0, 0);
        #1 checkOutput("coll_second", longint'(req_ready), 64'h1);
        checkOutput("coll_data_b", longint'(writeData), 64'hB);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("coll_data_a", longint'(writeData), 64'hA);
        step();
        checkOutput("coll_reg7", longint'(regs[7]), 64'hA);

        // Asynchronous reset while a write is on the port.
        applyStimulus(3'b001, 9, 0, 0, 32'h55, 0, 0);
        step();
        applyStimulus(3'b110, 0, 12, 13, 0, 32'h77, 32'h88);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_writeS", longint'(writeS), 64'h0);
        checkOutput("rst_cnt", longint'(commit_cnt), 64'd0);
        checkOutput("rst_ready", longint'(req_ready), 64'h0);
        rst = 1'b0;
        #1 checkOutput("post_rst_grant", longint'(req_ready), 64'h2);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("post_rst_addr", longint'(address3), 64'd12);

        // Counter saturation over 20 back-to-back writes.
        step();
        pulseReset();
        step();
        for (int c = 0; c < 20; c++) begin
            applyStimulus(3'b001, 3, 0, 0, 32'(c), 0, 0);
            step();
        end
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("sat_cnt", longint'(commit_cnt), longint'(CNT_MAX));

        // Randomized traffic honouring the hold-until-ready rule.
        step();
        pulseReset();
        cur_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            cur_a[i] = 0;
            cur_d[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!(cur_v[i] && !m_last_gnt[i])) begin
                    cur_v[i] = ($urandom_range(0, 2) != 0);
                    cur_a[i] = $urandom_range(0, 7);
                    cur_d[i] = $urandom;
                end
            end
            applyStimulus(cur_v, cur_a[0], cur_a[1], cur_a[2],
                          cur_d[0], cur_d[1], cur_d[2]);
        end
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
